// File: rtl/iomem_arbiter_if.sv
// Purpose: one iomem-style link (valid/ready request, byte strobes, 32-bit address/data).
// Latency: pure wiring, no state.
// Backpressure: the slave side holds ready low until the transfer completes; the master keeps valid high until then.
interface iomem_arbiter_if;
    logic        valid;
    logic        ready;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    // Requester side: drives the request and receives the completion.
    modport master (
        output valid,
        output wstrb,
        output addr,
        output wdata,
        input  ready,
        input  rdata
    );

    // Responder side: receives the request and drives the completion.
    modport slave (
        input  valid,
        input  wstrb,
        input  addr,
        input  wdata,
        output ready,
        output rdata
    );
endinterface

// File: rtl/iomem_arbiter.sv
// Purpose: two-requester (CPU=m0, DMA=m1) round-robin arbiter onto one shared iomem peripheral bus, with a watchdog timeout.
// Latency: grant one cycle after valid in IDLE; ready is returned in the same cycle as s_ready (or the timeout), then one IDLE cycle.
// Backpressure: the owner waits on s_ready; after TIMEOUT BUSY cycles without it, the owner is completed with ERR_RDATA and a sticky error is raised.
module iomem_arbiter #(
    parameter int unsigned TIMEOUT   = 255,
    parameter logic [31:0] ERR_RDATA = 32'hFFFF_FFFF
) (
    input  logic            clk,
    input  logic            resetn,
    iomem_arbiter_if.slave  m0,
    iomem_arbiter_if.slave  m1,
    iomem_arbiter_if.master s,
    output logic [1:0]      grant,
    output logic            timeout_err,
    input  logic            err_clr
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // The timeout fires when the counter (cleared on entering BUSY) reaches TIMEOUT-1.
    localparam logic [15:0] CNT_LIMIT = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;          // 0 = m0, 1 = m1
    logic        last_grant_q, last_grant_d;
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_err_q, timeout_err_d;
    logic [1:0]  grant_q, grant_d;

    logic        busy;
    logic        own_valid;
    logic [3:0]  own_wstrb;
    logic [31:0] own_addr;
    logic [31:0] own_wdata;
    logic        fwd_valid;
    logic        hit_ready;
    logic        hit_timeout;
    logic        finish;
    logic [31:0] done_rdata;

    // Select the current owner's request and classify this cycle's outcome.
    always_comb begin
        busy        = (state_q == ST_BUSY);
        own_valid   = owner_q ? m1.valid : m0.valid;
        own_wstrb   = owner_q ? m1.wstrb : m0.wstrb;
        own_addr    = owner_q ? m1.addr  : m0.addr;
        own_wdata   = owner_q ? m1.wdata : m0.wdata;
        fwd_valid   = busy & own_valid;
        // s_ready beats the timeout when both land in the same cycle.
        hit_ready   = fwd_valid & s.ready;
        hit_timeout = fwd_valid & ~s.ready & (cnt_q == CNT_LIMIT);
        finish      = hit_ready | hit_timeout;
        done_rdata  = hit_ready ? s.rdata : ERR_RDATA;
    end

    // Forward the owner's request to the shared bus; the bus is quiet in IDLE.
    always_comb begin
        s.valid = fwd_valid;
        s.wstrb = busy ? own_wstrb : 4'h0;
        s.addr  = busy ? own_addr  : 32'h0;
        s.wdata = busy ? own_wdata : 32'h0;
    end

    // Route the completion strobe and data to the owner only; the other side sees zeros.
    always_comb begin
        m0.ready = finish & ~owner_q;
        m1.ready = finish &  owner_q;
        m0.rdata = (finish & ~owner_q) ? done_rdata : 32'h0;
        m1.rdata = (finish &  owner_q) ? done_rdata : 32'h0;
    end

    // Next-state logic: arbitration in IDLE, completion / timeout / abort in BUSY.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        cnt_d         = cnt_q;
        grant_d       = grant_q;
        timeout_err_d = timeout_err_q;

        case (state_q)
            ST_IDLE: begin
                // s_ready is ignored here: nothing is outstanding.
                if (m0.valid | m1.valid) begin
                    state_d = ST_BUSY;
                    // Contention goes to whoever was not served last.
                    owner_d = (m0.valid & m1.valid) ? ~last_grant_q : m1.valid;
                    cnt_d   = 16'h0;
                    grant_d = owner_d ? 2'b10 : 2'b01;
                end
            end
            ST_BUSY: begin
                if (!own_valid) begin
                    // Requester withdrew: drop the transfer silently, fairness history untouched.
                    state_d = ST_IDLE;
                    grant_d = 2'b00;
                end else if (finish) begin
                    state_d      = ST_IDLE;
                    last_grant_d = owner_q;
                    grant_d      = 2'b00;
                end else begin
                    cnt_d = cnt_q + 16'h1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
            end
        endcase

        // A timeout in the same cycle as err_clr still leaves the flag set.
        if (hit_timeout) begin
            timeout_err_d = 1'b1;
        end else if (err_clr) begin
            timeout_err_d = 1'b0;
        end
    end

    // Arbiter state registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            cnt_q         <= 16'h0;
            grant_q       <= 2'b00;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            cnt_q         <= cnt_d;
            grant_q       <= grant_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign grant       = grant_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Purpose: self-checking bench for iomem_arbiter (vector table plus multi-cycle sequences, completions checked via a scoreboard).
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: the bench plays the peripheral and controls s_ready directly.
module tb_iomem_arbiter;

    localparam logic [31:0] A0  = 32'h0300_0000;
    localparam logic [31:0] A1  = 32'h0500_0004;
    localparam logic [31:0] ERR = 32'hFFFF_FFFF;

    logic clk;
    logic resetn;
    logic [1:0] grant;
    logic timeout_err;
    logic err_clr;

    iomem_arbiter_if m0_if ();
    iomem_arbiter_if m1_if ();
    iomem_arbiter_if s_if ();

    iomem_arbiter #(.TIMEOUT(8), .ERR_RDATA(ERR)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .m0         (m0_if),
        .m1         (m1_if),
        .s          (s_if),
        .grant      (grant),
        .timeout_err(timeout_err),
        .err_clr    (err_clr)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          who;
        logic [31:0] rdata;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        bit          rst;
        logic        m0v;
        logic        m1v;
        logic [3:0]  m1w;
        logic        sr;
        logic [31:0] srd;
        logic [1:0]  e_grant;
        logic        e_sv;
        logic        e_m0r;
        logic        e_m1r;
        logic [31:0] e_saddr;
        logic [3:0]  e_swstrb;
    } vec_t;
    vec_t vecs[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every completion strobe must match the next expected completion.
    always @(negedge clk) begin
        if (m0_if.ready === 1'b1 || m1_if.ready === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected m0_ready=%b m1_ready=%b expected no completion",
                         m0_if.ready, m1_if.ready);
            end else begin
                sb_t e;
                e = sb.pop_front();
                check("sb_both_ready", 32'(m0_if.ready & m1_if.ready), 32'd0);
                check("sb_who", 32'(m1_if.ready), 32'(e.who));
                check("sb_rdata", (e.who == 1) ? m1_if.rdata : m0_if.rdata, e.rdata);
                check("sb_other_rdata", (e.who == 1) ? m0_if.rdata : m1_if.rdata, 32'd0);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    function automatic vec_t mk(bit rst, logic m0v, logic m1v, logic [3:0] m1w, logic sr,
                                logic [31:0] srd, logic [1:0] eg, logic esv, logic em0r,
                                logic em1r, logic [31:0] ea, logic [3:0] ew);
        vec_t v;
        v.rst = rst; v.m0v = m0v; v.m1v = m1v; v.m1w = m1w; v.sr = sr; v.srd = srd;
        v.e_grant = eg; v.e_sv = esv; v.e_m0r = em0r; v.e_m1r = em1r;
        v.e_saddr = ea; v.e_swstrb = ew;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_if.valid = 1'b0; m0_if.wstrb = 4'h0;
        m1_if.valid = 1'b0; m1_if.wstrb = 4'h0;
        s_if.ready  = 1'b0; s_if.rdata  = 32'h0;
        err_clr     = 1'b0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b0;
        idle_inputs();
        m0_if.addr = A0; m0_if.wdata = 32'h1111_0000;
        m1_if.addr = A1; m1_if.wdata = 32'h2222_0001;

        // Reset state, with requests and s_ready pushed at the DUT.
        m0_if.valid = 1'b1; m1_if.valid = 1'b1; s_if.ready = 1'b1;
        sample();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_s_valid", 32'(s_if.valid), 32'd0);
        check("rst_m0_ready", 32'(m0_if.ready), 32'd0);
        check("rst_m1_ready", 32'(m1_if.ready), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        do_reset();

        // Single m0 read with s_ready one cycle after s_valid.
        vecs.push_back(mk(0, 1, 0, 4'h0, 0, 32'h0,  2'b00, 0, 0, 0, 32'h0, 4'h0));
        vecs.push_back(mk(0, 1, 0, 4'h0, 0, 32'h0,  2'b01, 1, 0, 0, A0,    4'h0));
        vecs.push_back(mk(0, 1, 0, 4'h0, 1, 32'hA5, 2'b01, 1, 1, 0, A0,    4'h0));
        vecs.push_back(mk(0, 0, 0, 4'h0, 0, 32'h0,  2'b00, 0, 0, 0, 32'h0, 4'h0));
        // Both requesting from reset, always-ready slave: m0, m1, m0, m1; s_ready in IDLE ignored.
        vecs.push_back(mk(1, 1, 1, 4'h3, 1, 32'hD0, 2'b00, 0, 0, 0, 32'h0, 4'h0));
        vecs.push_back(mk(0, 1, 1, 4'h3, 1, 32'hB1, 2'b01, 1, 1, 0, A0,    4'h0));
        vecs.push_back(mk(0, 1, 1, 4'h3, 1, 32'hB2, 2'b00, 0, 0, 0, 32'h0, 4'h0));
        vecs.push_back(mk(0, 1, 1, 4'h3, 1, 32'hB3, 2'b10, 1, 0, 1, A1,    4'h3));
        vecs.push_back(mk(0, 1, 1, 4'h3, 1, 32'hB4, 2'b00, 0, 0, 0, 32'h0, 4'h0));
        vecs.push_back(mk(0, 1, 1, 4'h3, 1, 32'hB5, 2'b01, 1, 1, 0, A0,    4'h0));
        vecs.push_back(mk(0, 1, 1, 4'h3, 1, 32'hB6, 2'b00, 0, 0, 0, 32'h0, 4'h0));
        vecs.push_back(mk(0, 1, 1, 4'h3, 1, 32'hB7, 2'b10, 1, 0, 1, A1,    4'h3));
        vecs.push_back(mk(0, 0, 0, 4'h0, 0, 32'h0,  2'b00, 0, 0, 0, 32'h0, 4'h0));

        foreach (vecs[i]) begin
            if (vecs[i].rst) do_reset();
            tick();
            m0_if.valid = vecs[i].m0v;
            m1_if.valid = vecs[i].m1v;
            m1_if.wstrb = vecs[i].m1w;
            s_if.ready  = vecs[i].sr;
            s_if.rdata  = vecs[i].srd;
            if (vecs[i].e_m0r) sb.push_back('{who: 0, rdata: vecs[i].srd});
            if (vecs[i].e_m1r) sb.push_back('{who: 1, rdata: vecs[i].srd});
            sample();
            check($sformatf("vec%0d_grant", i),    32'(grant),        32'(vecs[i].e_grant));
            check($sformatf("vec%0d_s_valid", i),  32'(s_if.valid),   32'(vecs[i].e_sv));
            check($sformatf("vec%0d_m0_ready", i), 32'(m0_if.ready),  32'(vecs[i].e_m0r));
            check($sformatf("vec%0d_m1_ready", i), 32'(m1_if.ready),  32'(vecs[i].e_m1r));
            check($sformatf("vec%0d_s_addr", i),   s_if.addr,         vecs[i].e_saddr);
            check($sformatf("vec%0d_s_wstrb", i),  32'(s_if.wstrb),   32'(vecs[i].e_swstrb));
        end

        // m1 write to a slave that never answers: timeout on the 8th BUSY cycle.
        do_reset();
        m1_if.wstrb = 4'hF; m1_if.valid = 1'b1;
        sb.push_back('{who: 1, rdata: ERR});
        sample();
        check("to_idle_grant", 32'(grant), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            sample();
            check($sformatf("to_m1_ready_c%0d", k), 32'(m1_if.ready), 32'(k == 8));
            if (k == 1) begin
                check("to_grant", 32'(grant), 32'b10);
                check("to_s_wstrb", 32'(s_if.wstrb), 32'hF);
                check("to_s_addr", s_if.addr, A1);
            end
            if (k == 8) check("to_err_not_yet", 32'(timeout_err), 32'd0);
        end
        tick();
        m1_if.valid = 1'b0; m1_if.wstrb = 4'h0;
        sample();
        check("to_err_set", 32'(timeout_err), 32'd1);
        check("to_grant_idle", 32'(grant), 32'd0);
        repeat (3) tick();
        sample();
        check("to_err_sticky", 32'(timeout_err), 32'd1);
        tick();
        err_clr = 1'b1;
        sample();
        check("to_err_before_clr_edge", 32'(timeout_err), 32'd1);
        tick();
        err_clr = 1'b0;
        sample();
        check("to_err_cleared", 32'(timeout_err), 32'd0);

        // err_clr held through a timeout: the set wins.
        m1_if.valid = 1'b1; err_clr = 1'b1;
        sb.push_back('{who: 1, rdata: ERR});
        for (int k = 0; k <= 8; k++) tick();
        m1_if.valid = 1'b0; err_clr = 1'b0;
        sample();
        check("clr_vs_set_err", 32'(timeout_err), 32'd1);

        // s_ready lands exactly on the timeout cycle: real data, no error.
        do_reset();
        m0_if.valid = 1'b1; s_if.rdata = 32'h1234_5678;
        sb.push_back('{who: 0, rdata: 32'h1234_5678});
        sample();
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 8) s_if.ready = 1'b1;
            sample();
            check($sformatf("race_m0_ready_c%0d", k), 32'(m0_if.ready), 32'(k == 8));
        end
        tick();
        m0_if.valid = 1'b0; s_if.ready = 1'b0;
        sample();
        check("race_err_clear", 32'(timeout_err), 32'd0);

        // Reset pulsed mid-BUSY: outputs drop at once, no ready, re-grant after release.
        do_reset();
        m0_if.valid = 1'b1;
        tick();
        tick();
        sample();
        check("mid_rst_busy_sv", 32'(s_if.valid), 32'd1);
        check("mid_rst_busy_grant", 32'(grant), 32'b01);
        #1;
        resetn = 1'b0; s_if.ready = 1'b1; s_if.rdata = 32'hDEAD_0001;
        #1;
        check("mid_rst_sv", 32'(s_if.valid), 32'd0);
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_m0_ready", 32'(m0_if.ready), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1; s_if.ready = 1'b0;
        sample();
        check("rel_idle_grant", 32'(grant), 32'd0);
        tick();
        sample();
        check("rel_regrant", 32'(grant), 32'b01);
        tick();
        s_if.ready = 1'b1; s_if.rdata = 32'hCAFE_0039;
        sb.push_back('{who: 0, rdata: 32'hCAFE_0039});
        sample();
        tick();
        m0_if.valid = 1'b0; s_if.ready = 1'b0;
        sample();
        check("rel_done_grant", 32'(grant), 32'd0);

        // Owner m0 withdraws in BUSY: abort, then pending m1 is served, no error.
        do_reset();
        m0_if.valid = 1'b1; m1_if.valid = 1'b1;
        tick();
        sample();
        check("abort_grant_m0", 32'(grant), 32'b01);
        tick();
        m0_if.valid = 1'b0;
        sample();
        check("abort_sv", 32'(s_if.valid), 32'd0);
        check("abort_m0_ready", 32'(m0_if.ready), 32'd0);
        tick();
        sample();
        check("abort_idle", 32'(grant), 32'd0);
        tick();
        s_if.ready = 1'b1; s_if.rdata = 32'h0BAD_F00D;
        sb.push_back('{who: 1, rdata: 32'h0BAD_F00D});
        sample();
        check("abort_m1_grant", 32'(grant), 32'b10);
        tick();
        m1_if.valid = 1'b0; s_if.ready = 1'b0;
        sample();
        check("abort_no_err", 32'(timeout_err), 32'd0);
        check("abort_end_grant", 32'(grant), 32'd0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iomem_arbiter.md
IOMEM_ARBITER -- requirements
Module: iomem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning BUSY cycles without s_ready before forced completion (range 2..65535).
REQ-002 SHALL have parameter ERR_RDATA, default 32'hFFFF_FFFF, meaning the read data returned on timeout.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 resetn  input  1  reset, asynchronous and active-low.
REQ-005 m0_valid / m1_valid  input  1  requester 0 (CPU) / requester 1 (DMA) transaction request.
REQ-006 m0_ready / m1_ready  output  1  completion strobe to that requester.
REQ-007 m0_wstrb / m1_wstrb  input  4  byte write strobes; 0 = read.
REQ-008 m0_addr / m1_addr  input  32  byte address.
REQ-009 m0_wdata / m1_wdata  input  32  write data.
REQ-010 m0_rdata / m1_rdata  output  32  read data to that requester.
REQ-011 s_valid  output  1  request to the shared peripheral bus.
REQ-012 s_ready  input  1  completion from the peripheral decoder.
REQ-013 s_wstrb / s_addr / s_wdata  output  4/32/32  forwarded from the granted requester.
REQ-014 s_rdata  input  32  peripheral read data.
REQ-015 grant  output  2  one-hot owner {m1,m0}; 2'b00 when idle.
REQ-016 timeout_err  output  1  sticky; set on any timeout.
REQ-017 err_clr  input  1  synchronous clear of timeout_err.

Function
REQ-018 FSM states SHALL be IDLE and BUSY, plus a registered owner bit and a last_grant bit.
REQ-019 In IDLE with exactly one mN_valid high, SHALL enter BUSY with owner=N on the next edge.
REQ-020 In IDLE with both valid, SHALL grant the requester not equal to last_grant (round-robin); after reset last_grant=1, so m0 wins first.
REQ-021 In BUSY, s_valid SHALL equal the owner's valid, and s_wstrb/s_addr/s_wdata SHALL combinationally follow the owner's inputs.
REQ-022 In IDLE, s_valid SHALL be 0 and s_wstrb SHALL be 0.
REQ-023 In BUSY with s_ready=1, the owner's mN_ready SHALL be 1 in the same cycle with mN_rdata=s_rdata; FSM SHALL return to IDLE and last_grant SHALL be set to owner.
REQ-024 Non-owner mN_ready SHALL be 0 and its mN_rdata SHALL be 0 at all times.
REQ-025 Minimum latency SHALL be 1 cycle from mN_valid rising (IDLE) to s_valid, so mN_ready no earlier than the 2nd cycle.
REQ-026 After each completion, one IDLE cycle SHALL precede the next grant (requester deasserts valid).
REQ-027 A 16-bit counter SHALL clear on entering BUSY and increment each BUSY cycle without s_ready.
REQ-028 When the counter reaches TIMEOUT-1 with s_ready=0, the owner SHALL get mN_ready=1 with mN_rdata=ERR_RDATA, timeout_err SHALL set, and FSM SHALL return to IDLE.
REQ-029 s_ready and timeout in the same cycle: s_ready SHALL win, with real data and no error.
REQ-030 Owner dropping valid in BUSY SHALL abort to IDLE next edge with no ready, no error, and last_grant unchanged.
REQ-031 err_clr and timeout in the same cycle: set SHALL win.
REQ-032 s_ready while IDLE SHALL be ignored.

Reset
REQ-033 resetn low SHALL force, asynchronously: state IDLE, grant 0, counter 0, last_grant 1, timeout_err 0, s_valid 0, all mN_ready 0.
REQ-034 Reset asserted mid-BUSY SHALL abandon the transaction without a ready pulse; after release, pending requests are re-arbitrated from scratch.

Verification
REQ-035 m0 read at 0x0300_0000, s_ready one cycle after s_valid, s_rdata=0x0000_00A5 -> m0_ready on cycle 3 with rdata 0xA5; grant 01 then 00.
REQ-036 m0 and m1 valid together from reset, always-ready slave -> order m0,m1,m0,m1; grant never 11.
REQ-037 m1 write 0x0500_0004 wstrb 4'hF, slave never ready, TIMEOUT=8 -> m1_ready after 8 BUSY cycles, rdata FFFF_FFFF, timeout_err=1 until err_clr.
REQ-038 s_ready on the exact timeout cycle -> real rdata delivered, timeout_err stays 0.
REQ-039 resetn pulsed low during m0 BUSY -> s_valid and grant drop immediately, no m0_ready; m0 is granted again 1 cycle after release.
REQ-040 m0 drops valid in BUSY -> IDLE next cycle, pending m1 granted after that, no error.
